ps2_line_buffer: RTL and testbench
==================================

# ps2_line_buffer

Parametrised keyboard line editor that sits between `PS2_Interface` and the processor/LOGO command path. It consumes raw PS/2 set-2 scan-code bytes, suppresses break and extended sequences, and maps make codes to ASCII. It assembles a DEPTH-character line with backspace and overflow handling, then presents the completed line to the consumer with a valid/ack handshake on Enter.

## Interface
- `DEPTH`, default 4: line capacity in characters; `line_data` is 8*DEPTH bits wide.
- `OVF_SHIFT`, default 1: behaviour on a printable character when full. 1 = shift the oldest character out; 0 = drop the new character.
- `CNT_W`, default 3: width of `char_count`; must satisfy 2^CNT_W > DEPTH.

- `clock` in 1: single clock; all state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle strobe; `key_data` holds a scan-code byte.
- `key_data` in 8: PS/2 set-2 byte.
- `line_ack` in 1: consumer has taken the line.
- `line_data` out 8*DEPTH: newest character in [7:0], older characters in successively higher bytes, unused bytes 0.
- `char_count` out CNT_W: number of characters held, 0..DEPTH.
- `line_valid` out 1: a line is complete and held.
- `overflow` out 1: sticky; a character arrived while the line was full.

## Operation
- **Prefix FSM**, advances only on `key_valid`:
  - S_MAKE: byte F0 → S_BREAK; byte E0 → S_EXT; any other byte is decoded as a make code, state stays S_MAKE.
  - S_BREAK: next byte is discarded → S_MAKE.
  - S_EXT: byte F0 → S_BREAK; any other byte is discarded (extended keys are unsupported) → S_MAKE.
- **Decode map:**
  - A–Z → 0x41–0x5A, using standard set-2 codes: A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A.
  - 0–9 → 0x30–0x39: 45,16,1E,26,25,2E,36,3D,3E,46.
  - Space 29 → 0x20.
  - Unmapped make codes are ignored. They are not stored as 0x00.
- **Printable make, `line_valid`=0:**
  - count < DEPTH: `line_data` <= {line_data[8*DEPTH-9:0], ascii}; count +1.
  - count = DEPTH: `overflow` <= 1. With OVF_SHIFT=1, shift anyway (oldest character lost, count stays DEPTH). With OVF_SHIFT=0, no data change.
- **Backspace (66), `line_valid`=0:**
  - count > 0: `line_data` shifts right 8 bits with zero fill; count −1.
  - count = 0: no-op.
- **Enter (5A), `line_valid`=0:**
  - count > 0: `line_valid` <= 1.
  - count = 0: ignored.
- **While `line_valid`=1:**
  - All make codes (printable, backspace, Enter) are ignored.
  - The prefix FSM keeps tracking, so the break sequence for Enter is still absorbed.
- **Acknowledge:**
  - `line_ack` with `line_valid`=1: next edge clears `line_data`, `char_count`, `overflow` and `line_valid`. The prefix FSM state is untouched.
  - `line_ack` with `line_valid`=0 is ignored.
- **Simultaneous `key_valid` and `line_ack` while valid:** the ack wins for data. The byte updates the prefix FSM only, and is never stored.
- Typematic repeats (repeated make codes with no break) are stored once per byte.

## Timing
- **Reset:** while `resetn` is low, outputs are asynchronously 0 (`line_data`, `char_count`, `line_valid`, `overflow`) and the FSM is in S_MAKE.
- **Reset mid-sequence:** a partially received prefix is discarded. The first byte after release is treated as a fresh byte in S_MAKE.
- **Latency:** one cycle. A byte strobed in cycle n is reflected on all outputs after edge n+1.
- **Back-to-back bytes:** `key_valid` high in consecutive cycles is legal; each cycle is one byte.
- All outputs are registered; there are no combinational input-to-output paths.
- `line_valid` stays high until acknowledged. The clear is visible one cycle after `line_ack` is sampled.

## Test plan
- **Basic entry**, DEPTH=4. Bytes 4B F0 4B 44 F0 44 34 F0 34 44 F0 44 → line_data=0x4C4F474F, char_count=4, overflow=0.
- **Prefix suppression.** Bytes 1C F0 1C E0 75 E0 F0 75 → line_data=0x00000041, count=1, FSM in S_MAKE.
- **Backspace.** Bytes 2B 23 66 → line_data=0x00000046, count=1. Then 66 66 → line_data=0, count=0, no underflow.
- **Overflow, both modes.** With OVF_SHIFT=1, type 1 2 3 4 5 → 0x32333435, count=4, overflow=1. With OVF_SHIFT=0, the same input → 0x31323334, overflow=1.
- **Handshake.**
  - Type "FD" then 5A → line_valid=1 one cycle later.
  - Then 1C and 66 → no change.
  - Pulse line_ack together with key_valid/1C → next cycle all outputs 0.
  - 5A with count=0 → line_valid stays 0.
- **Async reset mid-prefix.** Bytes 16 F0, then resetn low between edges → outputs 0 immediately. After release, byte 1C → line_data=0x00000041.

Source files
------------

// File: rtl/ps2_line_buffer.sv
// ps2_line_buffer: PS/2 set-2 scan-code line editor.
// Strips break (F0) and extended (E0) prefixes, maps make codes to ASCII,
// assembles a DEPTH-character line with backspace and overflow handling,
// and holds the finished line on Enter until the consumer acknowledges it.
module ps2_line_buffer #(
    parameter int DEPTH     = 4,
    parameter bit OVF_SHIFT = 1'b1,
    parameter int CNT_W     = 3
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 key_valid,
    input  logic [7:0]           key_data,
    input  logic                 line_ack,
    output logic [8*DEPTH-1:0]   line_data,
    output logic [CNT_W-1:0]     char_count,
    output logic                 line_valid,
    output logic                 overflow
);

    localparam int               LW       = 8 * DEPTH;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [7:0]       SC_BREAK = 8'hF0;
    localparam logic [7:0]       SC_EXT   = 8'hE0;
    localparam logic [7:0]       SC_BKSP  = 8'h66;
    localparam logic [7:0]       SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        S_MAKE  = 2'd0,
        S_BREAK = 2'd1,
        S_EXT   = 2'd2
    } state_t;

    state_t state;

    // Set-2 make code to ASCII; bit 8 flags a printable (mapped) key.
    function automatic logic [8:0] decode_make(input logic [7:0] sc);
        logic [8:0] r;
        case (sc)
            8'h1C: r = {1'b1, 8'h41};  // A
            8'h32: r = {1'b1, 8'h42};  // B
            8'h21: r = {1'b1, 8'h43};  // C
            8'h23: r = {1'b1, 8'h44};  // D
            8'h24: r = {1'b1, 8'h45};  // E
            8'h2B: r = {1'b1, 8'h46};  // F
            8'h34: r = {1'b1, 8'h47};  // G
            8'h33: r = {1'b1, 8'h48};  // H
            8'h43: r = {1'b1, 8'h49};  // I
            8'h3B: r = {1'b1, 8'h4A};  // J
            8'h42: r = {1'b1, 8'h4B};  // K
            8'h4B: r = {1'b1, 8'h4C};  // L
            8'h3A: r = {1'b1, 8'h4D};  // M
            8'h31: r = {1'b1, 8'h4E};  // N
            8'h44: r = {1'b1, 8'h4F};  // O
            8'h4D: r = {1'b1, 8'h50};  // P
            8'h15: r = {1'b1, 8'h51};  // Q
            8'h2D: r = {1'b1, 8'h52};  // R
            8'h1B: r = {1'b1, 8'h53};  // S
            8'h2C: r = {1'b1, 8'h54};  // T
            8'h3C: r = {1'b1, 8'h55};  // U
            8'h2A: r = {1'b1, 8'h56};  // V
            8'h1D: r = {1'b1, 8'h57};  // W
            8'h22: r = {1'b1, 8'h58};  // X
            8'h35: r = {1'b1, 8'h59};  // Y
            8'h1A: r = {1'b1, 8'h5A};  // Z
            8'h45: r = {1'b1, 8'h30};  // 0
            8'h16: r = {1'b1, 8'h31};  // 1
            8'h1E: r = {1'b1, 8'h32};  // 2
            8'h26: r = {1'b1, 8'h33};  // 3
            8'h25: r = {1'b1, 8'h34};  // 4
            8'h2E: r = {1'b1, 8'h35};  // 5
            8'h36: r = {1'b1, 8'h36};  // 6
            8'h3D: r = {1'b1, 8'h37};  // 7
            8'h3E: r = {1'b1, 8'h38};  // 8
            8'h46: r = {1'b1, 8'h39};  // 9
            8'h29: r = {1'b1, 8'h20};  // space
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    // Stage p0: classify the incoming byte as seen from the prefix FSM.
    logic       make_vld_p0;
    logic       printable_p0;
    logic [7:0] ascii_p0;
    logic       bksp_p0;
    logic       enter_p0;
    logic       clear_p0;

    // Combinational decode of the current byte; only a make code in S_MAKE counts.
    always_comb begin
        make_vld_p0  = 1'b0;
        printable_p0 = 1'b0;
        ascii_p0     = 8'h00;
        bksp_p0      = 1'b0;
        enter_p0     = 1'b0;
        if (key_valid && (state == S_MAKE) &&
            (key_data != SC_BREAK) && (key_data != SC_EXT)) begin
            make_vld_p0 = 1'b1;
        end
        {printable_p0, ascii_p0} = decode_make(key_data);
        printable_p0 = printable_p0 & make_vld_p0;
        bksp_p0      = make_vld_p0 && (key_data == SC_BKSP);
        enter_p0     = make_vld_p0 && (key_data == SC_ENTER);
        // An acknowledge of a held line takes precedence over any byte for the data path.
        clear_p0     = line_valid && line_ack;
    end

    // Prefix tracker: absorbs F0/E0 sequences; runs regardless of line state or ack.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_MAKE;
        end else if (key_valid) begin
            case (state)
                S_MAKE: begin
                    if (key_data == SC_BREAK)      state <= S_BREAK;
                    else if (key_data == SC_EXT)   state <= S_EXT;
                    else                           state <= S_MAKE;
                end
                S_BREAK: state <= S_MAKE;
                S_EXT: begin
                    if (key_data == SC_BREAK)      state <= S_BREAK;
                    else                           state <= S_MAKE;
                end
                default: state <= S_MAKE;
            endcase
        end
    end

    // Stage p1: line storage, count, completion and overflow flags (registered outputs).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            line_data  <= '0;
            char_count <= '0;
            line_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear_p0) begin
            line_data  <= '0;
            char_count <= '0;
            line_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (!line_valid) begin
            if (printable_p0) begin
                if (char_count < FULL) begin
                    line_data  <= (line_data << 8) | LW'(ascii_p0);
                    char_count <= char_count + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                    // Shift mode keeps the most recent DEPTH characters.
                    if (OVF_SHIFT) begin
                        line_data <= (line_data << 8) | LW'(ascii_p0);
                    end
                end
            end else if (bksp_p0) begin
                if (char_count != '0) begin
                    line_data  <= line_data >> 8;
                    char_count <= char_count - CNT_W'(1);
                end
            end else if (enter_p0) begin
                if (char_count != '0) begin
                    line_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Bench for ps2_line_buffer: two instances (shift and drop overflow modes)
// share the stimulus; a behavioural character-list model feeds a scoreboard.
module tb_ps2_line_buffer;

    logic        clock;
    logic        resetn;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        line_ack;

    logic [31:0] ld1, ld0;
    logic [2:0]  cnt1, cnt0;
    logic        lv1, lv0;
    logic        ov1, ov0;

    int checks = 0;
    int errors = 0;

    ps2_line_buffer #(.DEPTH(4), .OVF_SHIFT(1'b1), .CNT_W(3)) dut1 (
        .clock(clock), .resetn(resetn), .key_valid(key_valid), .key_data(key_data),
        .line_ack(line_ack), .line_data(ld1), .char_count(cnt1),
        .line_valid(lv1), .overflow(ov1)
    );

    ps2_line_buffer #(.DEPTH(4), .OVF_SHIFT(1'b0), .CNT_W(3)) dut0 (
        .clock(clock), .resetn(resetn), .key_valid(key_valid), .key_data(key_data),
        .line_ack(line_ack), .line_data(ld0), .char_count(cnt0),
        .line_valid(lv0), .overflow(ov0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d0;
        logic [2:0]  c1;
        logic [2:0]  c0;
        logic        v;
        logic        o;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] q1[$];   // shift-mode characters, oldest first
    logic [7:0] q0[$];   // drop-mode characters, oldest first
    int         m_st;    // 0 make, 1 break, 2 extended
    bit         m_valid;
    bit         m_ovf;

    // Scan codes for A..Z followed by 0..9
    logic [7:0] codes [36] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    function automatic int lookup(input logic [7:0] sc);
        if (sc == 8'h29) return 32'h20;
        for (int i = 0; i < 36; i++) begin
            if (codes[i] == sc) return (i < 26) ? (32'h41 + i) : (32'h30 + i - 26);
        end
        return -1;
    endfunction

    function automatic logic [31:0] pack(input bit shift_mode);
        logic [31:0] r = 32'h0;
        int n = shift_mode ? q1.size() : q0.size();
        for (int i = 0; i < n; i++) begin
            logic [7:0] ch = shift_mode ? q1[n-1-i] : q0[n-1-i];
            r = r | (32'(ch) << (8*i));
        end
        return r;
    endfunction

    task automatic push_expect();
        exp_t e;
        e.d1 = pack(1'b1);
        e.d0 = pack(1'b0);
        e.c1 = 3'(q1.size());
        e.c0 = 3'(q0.size());
        e.v  = m_valid;
        e.o  = m_ovf;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        m_st    = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic kv, input logic [7:0] kd, input logic ack);
        bit make = 1'b0;
        int a;
        if (kv) begin
            if (m_st == 0) begin
                if (kd == 8'hF0) m_st = 1;
                else if (kd == 8'hE0) m_st = 2;
                else make = 1'b1;
            end else if (m_st == 1) begin
                m_st = 0;
            end else begin
                m_st = (kd == 8'hF0) ? 1 : 0;
            end
        end
        if (m_valid && ack) begin
            model_reset_data();
        end else if (!m_valid && make) begin
            a = lookup(kd);
            if (a >= 0) begin
                if (q1.size() < 4) begin
                    q1.push_back(8'(a));
                    q0.push_back(8'(a));
                end else begin
                    m_ovf = 1'b1;
                    void'(q1.pop_front());
                    q1.push_back(8'(a));
                end
            end else if (kd == 8'h66) begin
                if (q1.size() > 0) begin
                    void'(q1.pop_back());
                    void'(q0.pop_back());
                end
            end else if (kd == 8'h5A) begin
                if (q1.size() > 0) m_valid = 1'b1;
            end
        end
        push_expect();
    endtask

    task automatic model_reset_data();
        q1.delete();
        q0.delete();
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_data1"}, ld1, e.d1);
        chk({tag, "_data0"}, ld0, e.d0);
        chk({tag, "_cnt1"}, 32'(cnt1), 32'(e.c1));
        chk({tag, "_cnt0"}, 32'(cnt0), 32'(e.c0));
        chk({tag, "_valid"}, 32'({lv1, lv0}), 32'({e.v, e.v}));
        chk({tag, "_ovf"}, 32'({ov1, ov0}), 32'({e.o, e.o}));
    endtask

    task automatic send(input string tag, input logic kv, input logic [7:0] kd, input logic ack);
        @(negedge clock);
        key_valid = kv;
        key_data  = kd;
        line_ack  = ack;
        model_step(kv, kd, ack);
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        line_ack  = 1'b0;
        check_sb(tag);
    endtask

    task automatic key(input string tag, input logic [7:0] kd);
        send(tag, 1'b1, kd, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data1"}, ld1, 32'h0);
        chk({tag, "_data0"}, ld0, 32'h0);
        chk({tag, "_cnt"}, 32'({cnt1, cnt0}), 32'h0);
        chk({tag, "_flags"}, 32'({lv1, lv0, ov1, ov0}), 32'h0);
    endtask

    initial begin
        logic [7:0] basic [12] = '{8'h4B, 8'hF0, 8'h4B, 8'h44, 8'hF0, 8'h44,
                                   8'h34, 8'hF0, 8'h34, 8'h44, 8'hF0, 8'h44};
        logic [7:0] pref [8]   = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        logic [7:0] digs [5]   = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

        resetn    = 1'b1;
        key_valid = 1'b0;
        key_data  = 8'h00;
        line_ack  = 1'b0;
        model_reset();
        #1 resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        @(negedge clock);
        resetn = 1'b1;

        // Basic entry "LOGO" with break codes
        foreach (basic[i]) key("basic", basic[i]);
        chk("basic_line", ld1, 32'h4C4F474F);
        chk("basic_cnt", 32'(cnt1), 32'd4);
        chk("basic_ovf", 32'(ov1), 32'd0);
        key("basic_enter", 8'h5A);
        key("basic_brk", 8'hF0);
        key("basic_brk2", 8'h5A);
        send("basic_ack", 1'b0, 8'h00, 1'b1);

        // Prefix suppression, then a fresh make proves the tracker is back in make state
        foreach (pref[i]) key("prefix", pref[i]);
        chk("prefix_line", ld1, 32'h00000041);
        chk("prefix_cnt", 32'(cnt1), 32'd1);
        key("prefix_next", 8'h32);
        chk("prefix_next_line", ld1, 32'h00004142);
        key("prefix_bs", 8'h66);
        key("prefix_bs", 8'h66);

        // Backspace, including underflow attempt
        key("bs_f", 8'h2B);
        key("bs_d", 8'h23);
        key("bs_1", 8'h66);
        chk("bs_line", ld1, 32'h00000046);
        key("bs_2", 8'h66);
        key("bs_3", 8'h66);
        chk("bs_empty", 32'({ld1, 5'(cnt1)}), 32'h0);

        // Overflow in both modes, typematic repeat of '5' included via back-to-back bytes
        foreach (digs[i]) key("ovf", digs[i]);
        chk("ovf_shift_line", ld1, 32'h32333435);
        chk("ovf_drop_line", ld0, 32'h31323334);
        chk("ovf_flags", 32'({ov1, ov0}), 32'b11);
        key("ovf_rep", 8'h2E);
        chk("ovf_rep_line", ld1, 32'h33343535);
        key("ovf_enter", 8'h5A);
        send("ovf_ack", 1'b0, 8'h00, 1'b1);

        // Handshake
        key("hs_f", 8'h2B);
        key("hs_d", 8'h23);
        key("hs_enter", 8'h5A);
        chk("hs_valid", 32'(lv1), 32'd1);
        key("hs_ign_a", 8'h1C);
        key("hs_ign_bs", 8'h66);
        chk("hs_hold", ld1, 32'h00004644);
        send("hs_ack", 1'b1, 8'h1C, 1'b1);
        check_zero("hs_cleared");
        key("hs_enter_empty", 8'h5A);
        chk("hs_enter_empty_v", 32'(lv1), 32'd0);
        key("hs_a", 8'h1C);
        send("hs_stray_ack", 1'b0, 8'h00, 1'b1);
        chk("hs_stray_ack_line", ld1, 32'h00000041);
        key("hs_bs", 8'h66);

        // Async reset in the middle of a break prefix
        key("ar_1", 8'h16);
        key("ar_f0", 8'hF0);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check_zero("ar_async");
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        key("ar_a", 8'h1C);
        chk("ar_line", ld1, 32'h00000041);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
